// File: rtl/rx_phy_pkg.sv
// Shared RX PHY definitions: deskew controller states, symbol codes, default skew limit.
package rx_phy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOCK,
    WINDOW,
    CATCH,
    ALIGNED,
    FLUSH,
    FAIL
  } rx_state_e;

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;

  localparam int unsigned DEF_MAX_SKEW = 4;

endpackage

// File: rtl/rx_skew_checker.sv
// Tracks which lanes have delivered COM since arming and decides pass/fail
// against the allowed lane-to-lane skew.
module rx_skew_checker
  import rx_phy_pkg::*;
#(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned MAX_SKEW  = DEF_MAX_SKEW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic [NUM_LANES-1:0] com_seen,
  output logic                 pass_c,
  output logic                 fail_c
);

  localparam int unsigned SKEW_W = $clog2(MAX_SKEW + 1);

  logic [NUM_LANES-1:0] seen_mask;
  logic [NUM_LANES-1:0] mask_now;
  logic [SKEW_W-1:0]    skew_cnt;

  // Current cycle's pulses count toward the pass decision immediately.
  assign mask_now = seen_mask | com_seen;
  assign pass_c   = arm && (&mask_now) && (skew_cnt < SKEW_W'(MAX_SKEW));
  assign fail_c   = arm && (skew_cnt == SKEW_W'(MAX_SKEW));

  // Accumulate COM arrivals and age the window from the first one; disarm clears.
  always_ff @(posedge clk) begin
    if (reset || !arm) begin
      seen_mask <= '0;
      skew_cnt  <= '0;
    end else begin
      seen_mask <= mask_now;
      if ((|mask_now) && (skew_cnt != SKEW_W'(MAX_SKEW))) begin
        skew_cnt <= skew_cnt + SKEW_W'(1);
      end
    end
  end

endmodule

// File: rtl/rx_deskew_ctrl.sv
// RX deskew sequencer: waits for TS lock on all lanes, runs the skew window,
// catches COM on every lane, and flushes/retries until aligned or failed.
module rx_deskew_ctrl
  import rx_phy_pkg::*;
#(
  parameter int unsigned NUM_LANES    = 2,
  parameter int unsigned MAX_SKEW     = DEF_MAX_SKEW,
  parameter int unsigned RETRY_MAX    = 3,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_LANES-1:0] ts_obtained,
  input  logic [NUM_LANES-1:0] com_seen,
  input  logic [NUM_LANES-1:0] fifo_not_empty,
  output logic                 deskew_en,
  output logic                 fifo_flush,
  output logic                 lanes_aligned,
  output logic                 align_fail,
  output logic [1:0]           retry_cnt,
  output logic [2:0]           window_cnt
);

  localparam int unsigned FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  rx_state_e          state;
  rx_state_e          state_nxt;
  logic [FLUSH_W-1:0] flush_cnt;
  logic               ts_all;
  logic               chk_pass;
  logic               chk_fail;
  logic               unused_fne;

  assign ts_all = &ts_obtained;

  // FIFO occupancy is not needed for sequencing; kept on the interface for the lane logic.
  assign unused_fne = ^fifo_not_empty;

  rx_skew_checker #(
    .NUM_LANES (NUM_LANES),
    .MAX_SKEW  (MAX_SKEW)
  ) u_skew_checker (
    .clk      (clk),
    .reset    (reset),
    .arm      (state == CATCH),
    .com_seen (com_seen),
    .pass_c   (chk_pass),
    .fail_c   (chk_fail)
  );

  // Next-state selection; enable low overrides everything but reset.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      state_nxt = WAIT_LOCK;
        WAIT_LOCK: if (ts_all) state_nxt = WINDOW;
        WINDOW: begin
          if (!ts_all)                             state_nxt = WAIT_LOCK;
          else if (window_cnt == 3'(MAX_SKEW))     state_nxt = CATCH;
        end
        CATCH: begin
          if (!ts_all)       state_nxt = FLUSH;
          else if (chk_pass) state_nxt = ALIGNED;
          else if (chk_fail) state_nxt = FLUSH;
        end
        ALIGNED:   if (!ts_all) state_nxt = FLUSH;
        FLUSH: begin
          if (flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1)) begin
            state_nxt = (retry_cnt == 2'(RETRY_MAX)) ? FAIL : WAIT_LOCK;
          end
        end
        FAIL:      state_nxt = FAIL;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // State, counters and registered Moore outputs (decoded from the state being entered).
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      window_cnt    <= 3'd1;
      retry_cnt     <= 2'd0;
      flush_cnt     <= '0;
      deskew_en     <= 1'b0;
      fifo_flush    <= 1'b0;
      lanes_aligned <= 1'b0;
      align_fail    <= 1'b0;
    end else begin
      state         <= state_nxt;
      deskew_en     <= (state_nxt == CATCH) || (state_nxt == ALIGNED);
      lanes_aligned <= (state_nxt == ALIGNED);
      align_fail    <= (state_nxt == FAIL);
      // One-cycle flush on an enable drop also drains whatever was caught.
      fifo_flush    <= (state_nxt == FLUSH) ||
                       (!enable && ((state == CATCH) || (state == ALIGNED)));

      if ((state == WINDOW) && (state_nxt == WINDOW)) begin
        window_cnt <= window_cnt + 3'd1;
      end else if ((state_nxt != CATCH) && (state_nxt != ALIGNED)) begin
        window_cnt <= 3'd1;
      end

      if (state_nxt == IDLE) begin
        retry_cnt <= 2'd0;
      end else if ((state == CATCH) && (state_nxt == ALIGNED)) begin
        retry_cnt <= 2'd0;
      end else if ((state == CATCH) && (state_nxt == FLUSH) && ts_all &&
                   (retry_cnt != 2'd3)) begin
        retry_cnt <= retry_cnt + 2'd1;
      end

      if ((state == FLUSH) && (state_nxt == FLUSH)) begin
        flush_cnt <= flush_cnt + FLUSH_W'(1);
      end else begin
        flush_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rx_deskew_ctrl.sv
// Bench for rx_deskew_ctrl: directed scenarios plus randomized traffic against
// an arrival-timestamp reference model.
module tb_rx_deskew_ctrl;

  localparam int NL = 2;
  localparam int MS = 4;
  localparam int RM = 3;
  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic [1:0] ts, com, fne;
  logic       deskew_en, fifo_flush, lanes_aligned, align_fail;
  logic [1:0] retry_cnt;
  logic [2:0] window_cnt;

  int total = 0;
  int bad   = 0;

  rx_deskew_ctrl #(
    .NUM_LANES(NL), .MAX_SKEW(MS), .RETRY_MAX(RM), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .ts_obtained(ts),
    .com_seen(com), .fifo_not_empty(fne), .deskew_en(deskew_en),
    .fifo_flush(fifo_flush), .lanes_aligned(lanes_aligned),
    .align_fail(align_fail), .retry_cnt(retry_cnt), .window_cnt(window_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: phase plus per-lane COM arrival timestamps.
  localparam int P_IDLE = 0, P_LOCK = 1, P_WIN = 2, P_CATCH = 3;
  localparam int P_ALIGN = 4, P_FLUSH = 5, P_FAIL = 6;

  int ph = P_IDLE;
  int win = 1;
  int retries = 0;
  int flush_left = 0;
  int cyc = 0;
  int arr[NL];
  bit e_desk, e_flush, e_al, e_fail;

  function automatic void go_flush();
    ph = P_FLUSH;
    flush_left = FC;
    win = 1;
  endfunction

  // Advance the model by one clock using the inputs about to be sampled.
  function automatic void model_step();
    bit all_ts;
    bit all_in;
    int first;
    all_ts = (ts == 2'b11);
    e_flush = 1'b0;
    cyc++;
    if (reset) begin
      ph = P_IDLE; win = 1; retries = 0;
    end else if (!enable) begin
      e_flush = (ph == P_CATCH) || (ph == P_ALIGN);
      ph = P_IDLE; win = 1; retries = 0;
    end else begin
      case (ph)
        P_IDLE: ph = P_LOCK;
        P_LOCK: begin
          win = 1;
          if (all_ts) ph = P_WIN;
        end
        P_WIN: begin
          if (!all_ts) begin
            ph = P_LOCK; win = 1;
          end else if (win == MS) begin
            ph = P_CATCH;
            for (int i = 0; i < NL; i++) arr[i] = -1;
          end else begin
            win++;
          end
        end
        P_CATCH: begin
          if (!all_ts) begin
            go_flush();
          end else begin
            for (int i = 0; i < NL; i++)
              if (arr[i] < 0 && com[i]) arr[i] = cyc;
            all_in = 1'b1;
            first = -1;
            for (int i = 0; i < NL; i++) begin
              if (arr[i] < 0) all_in = 1'b0;
              else if (first < 0 || arr[i] < first) first = arr[i];
            end
            if (first >= 0) begin
              if (all_in && (cyc - first) < MS) begin
                ph = P_ALIGN; retries = 0;
              end else if ((cyc - first) >= MS) begin
                retries = (retries < 3) ? retries + 1 : 3;
                go_flush();
              end
            end
          end
        end
        P_ALIGN: if (!all_ts) go_flush();
        P_FLUSH: begin
          flush_left--;
          if (flush_left == 0) ph = (retries == RM) ? P_FAIL : P_LOCK;
        end
        default: ;
      endcase
    end
    e_desk  = (ph == P_CATCH) || (ph == P_ALIGN);
    e_al    = (ph == P_ALIGN);
    e_fail  = (ph == P_FAIL);
    e_flush = e_flush || (ph == P_FLUSH);
  endfunction

  // One clock: model consumes current inputs, DUT outputs are sampled on the falling edge.
  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  // From any state: drop enable, then run lock and window with all lanes locked until CATCH.
  task automatic acquire();
    com = 2'b00; ts = 2'b11; enable = 1'b0;
    step();
    enable = 1'b1;
    repeat (6) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; ts = 2'b11; com = 2'b11;
    step(); step();
    total++;
    if ({deskew_en, fifo_flush, lanes_aligned, align_fail, retry_cnt, window_cnt} !== 9'b0000_00_001) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=000000001",
               {deskew_en, fifo_flush, lanes_aligned, align_fail, retry_cnt, window_cnt});
    end
    reset = 1'b0; enable = 1'b0; com = 2'b00;
    step();
    total++;
    if ({deskew_en, fifo_flush, lanes_aligned, align_fail, retry_cnt, window_cnt} !== 9'b0000_00_001) begin
      bad++;
      $display("FAIL idle_outputs got=%b want=000000001",
               {deskew_en, fifo_flush, lanes_aligned, align_fail, retry_cnt, window_cnt});
    end
  endtask

  task automatic test_nominal();
    enable = 1'b1; ts = 2'b01; com = 2'b00;
    step(); step();
    ts = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (window_cnt !== 3'(k + 1) || deskew_en !== 1'b0) begin
        bad++;
        $display("FAIL nominal_window k=%0d got win=%0d desk=%b want win=%0d desk=0",
                 k, window_cnt, deskew_en, k + 1);
      end
    end
    step();
    total++;
    if (deskew_en !== 1'b1 || window_cnt !== 3'd4) begin
      bad++;
      $display("FAIL nominal_catch got desk=%b win=%0d want desk=1 win=4", deskew_en, window_cnt);
    end
    com = 2'b11;
    step();
    com = 2'b00;
    total++;
    if (lanes_aligned !== 1'b1 || retry_cnt !== 2'd0 || deskew_en !== 1'b1) begin
      bad++;
      $display("FAIL nominal_aligned got al=%b retry=%0d desk=%b want al=1 retry=0 desk=1",
               lanes_aligned, retry_cnt, deskew_en);
    end
  endtask

  task automatic test_max_skew();
    acquire();
    com = 2'b01; step();
    com = 2'b00; step(); step();
    com = 2'b10; step();
    com = 2'b00;
    total++;
    if (lanes_aligned !== 1'b1) begin
      bad++;
      $display("FAIL skew3_aligned got al=%b want 1", lanes_aligned);
    end
    acquire();
    com = 2'b01; step();
    com = 2'b00; step(); step(); step();
    com = 2'b10; step();
    com = 2'b00;
    total++;
    if (fifo_flush !== 1'b1 || lanes_aligned !== 1'b0 || deskew_en !== 1'b0 || retry_cnt !== 2'd1) begin
      bad++;
      $display("FAIL skew4_flush1 got fl=%b al=%b desk=%b retry=%0d want fl=1 al=0 desk=0 retry=1",
               fifo_flush, lanes_aligned, deskew_en, retry_cnt);
    end
    step();
    total++;
    if (fifo_flush !== 1'b1) begin
      bad++;
      $display("FAIL skew4_flush2 got fl=%b want 1", fifo_flush);
    end
    step();
    total++;
    if (fifo_flush !== 1'b0 || retry_cnt !== 2'd1 || window_cnt !== 3'd1 || deskew_en !== 1'b0) begin
      bad++;
      $display("FAIL skew4_relock got fl=%b retry=%0d win=%0d desk=%b want fl=0 retry=1 win=1 desk=0",
               fifo_flush, retry_cnt, window_cnt, deskew_en);
    end
  endtask

  task automatic test_retry_exhaust();
    acquire();
    for (int k = 0; k < 3; k++) begin
      com = 2'b01; step();
      com = 2'b00;
      repeat (4) step();
      total++;
      if (fifo_flush !== 1'b1 || retry_cnt !== 2'(k + 1)) begin
        bad++;
        $display("FAIL retry_step k=%0d got fl=%b retry=%0d want fl=1 retry=%0d",
                 k, fifo_flush, retry_cnt, k + 1);
      end
      step(); step();
      if (k < 2) repeat (5) step();
    end
    repeat (3) step();
    total++;
    if (align_fail !== 1'b1 || retry_cnt !== 2'd3 || deskew_en !== 1'b0 || fifo_flush !== 1'b0) begin
      bad++;
      $display("FAIL retry_fail_hold got af=%b retry=%0d desk=%b fl=%b want af=1 retry=3 desk=0 fl=0",
               align_fail, retry_cnt, deskew_en, fifo_flush);
    end
    enable = 1'b0;
    step();
    total++;
    if ({deskew_en, fifo_flush, lanes_aligned, align_fail, retry_cnt, window_cnt} !== 9'b0000_00_001) begin
      bad++;
      $display("FAIL retry_disable got=%b want=000000001",
               {deskew_en, fifo_flush, lanes_aligned, align_fail, retry_cnt, window_cnt});
    end
  endtask

  task automatic test_lock_loss();
    acquire();
    com = 2'b11; step();
    com = 2'b00;
    ts = 2'b01; step();
    total++;
    if (fifo_flush !== 1'b1 || lanes_aligned !== 1'b0 || retry_cnt !== 2'd0) begin
      bad++;
      $display("FAIL lockloss_flush got fl=%b al=%b retry=%0d want fl=1 al=0 retry=0",
               fifo_flush, lanes_aligned, retry_cnt);
    end
    step(); step();
    total++;
    if (fifo_flush !== 1'b0 || window_cnt !== 3'd1 || retry_cnt !== 2'd0 || deskew_en !== 1'b0) begin
      bad++;
      $display("FAIL lockloss_relock got fl=%b win=%0d retry=%0d desk=%b want fl=0 win=1 retry=0 desk=0",
               fifo_flush, window_cnt, retry_cnt, deskew_en);
    end
    ts = 2'b11;
  endtask

  task automatic test_window_abort();
    logic desk_seen;
    desk_seen = 1'b0;
    enable = 1'b0; ts = 2'b11; com = 2'b00;
    step();
    enable = 1'b1;
    repeat (4) begin
      step();
      desk_seen = desk_seen | deskew_en;
    end
    total++;
    if (window_cnt !== 3'd3) begin
      bad++;
      $display("FAIL abort_pre got win=%0d want 3", window_cnt);
    end
    ts = 2'b10;
    repeat (4) begin
      step();
      desk_seen = desk_seen | deskew_en;
    end
    total++;
    if (window_cnt !== 3'd1 || desk_seen !== 1'b0) begin
      bad++;
      $display("FAIL abort_relock got win=%0d desk_seen=%b want win=1 desk_seen=0", window_cnt, desk_seen);
    end
    ts = 2'b11;
  endtask

  task automatic test_reset_mid_catch();
    acquire();
    com = 2'b01; step();
    com = 2'b00;
    reset = 1'b1; step();
    reset = 1'b0;
    total++;
    if ({deskew_en, fifo_flush, lanes_aligned, align_fail, retry_cnt, window_cnt} !== 9'b0000_00_001) begin
      bad++;
      $display("FAIL midcatch_reset got=%b want=000000001",
               {deskew_en, fifo_flush, lanes_aligned, align_fail, retry_cnt, window_cnt});
    end
    repeat (6) step();
    total++;
    if (deskew_en !== 1'b1 || window_cnt !== 3'd4) begin
      bad++;
      $display("FAIL midcatch_rerun got desk=%b win=%0d want desk=1 win=4", deskew_en, window_cnt);
    end
    com = 2'b10; step();
    com = 2'b00;
    total++;
    if (lanes_aligned !== 1'b0 || deskew_en !== 1'b1) begin
      bad++;
      $display("FAIL midcatch_mask_cleared got al=%b desk=%b want al=0 desk=1", lanes_aligned, deskew_en);
    end
  endtask

  task automatic test_random();
    logic [8:0] got, want;
    reset = 1'b1; enable = 1'b1; ts = 2'b11; com = 2'b00;
    step();
    reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 79) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      ts  = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      com = {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)};
      fne = 2'($urandom);
      step();
      got  = {deskew_en, fifo_flush, lanes_aligned, align_fail, retry_cnt, window_cnt};
      want = {e_desk, e_flush, e_al, e_fail, 2'(retries), 3'(win)};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL random n=%0d got=%b want=%b (desk,flush,al,fail,retry,win)", n, got, want);
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; ts = 2'b00; com = 2'b00; fne = 2'b00;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_max_skew();
    test_retry_exhaust();
    test_lock_loss();
    test_window_abort();
    test_reset_mid_catch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_deskew_ctrl.md
Name: rx_deskew_ctrl

Overview:
Sequencing controller for the multi-lane PHY RX deskew path. It waits for every lane to obtain a Training Set, then runs the skew window counter. It then enables the deskew FIFOs and checks that COM arrives on all lanes within the allowed skew. On failure it flushes the FIFOs and retries. It reports aligned/failed status to LTSSM and sits between the per-lane RX logic and LTSSM.

Parameters:
NUM_LANES, 2, number of lanes supervised
MAX_SKEW, 4, maximum lane-to-lane skew in clk cycles; also the terminal value of the window count
RETRY_MAX, 3, failed alignment attempts allowed before declaring failure
FLUSH_CYCLES, 2, cycles fifo_flush is held per flush

Ports:
clk  in  1  local RX clock, same domain as the deskew FIFO read side
reset  in  1  synchronous, active-high reset
enable  in  1  LTSSM request to acquire/hold lane alignment
ts_obtained  in  NUM_LANES  per-lane TS-detected flag
com_seen  in  NUM_LANES  per-lane one-cycle pulse: COM written into that lane's deskew FIFO
fifo_not_empty  in  NUM_LANES  per-lane deskew FIFO not-empty
deskew_en  out  1  allows deskew FIFOs to catch COM and fill
fifo_flush  out  1  clears all deskew FIFOs
lanes_aligned  out  1  alignment achieved and held
align_fail  out  1  retries exhausted
retry_cnt  out  2  failed attempts so far
window_cnt  out  3  current skew-window count, for debug

Behaviour:
- Reset: state IDLE; window_cnt=1; skew_cnt=0; seen_mask=0; retry_cnt=0; all 1-bit outputs 0.
- reset has priority over all other inputs.
- Moore outputs are decoded from registered state.
- IDLE: all outputs 0. When enable=1, go to WAIT_LOCK next cycle.
- WAIT_LOCK: window_cnt held at 1. When &ts_obtained, go to WINDOW.
- WINDOW: window_cnt increments by 1 per cycle.
  - At window_cnt==MAX_SKEW, go to CATCH; window_cnt saturates there.
  - If any ts_obtained bit drops, go to WAIT_LOCK and reload window_cnt to 1.
- CATCH: deskew_en=1.
  - Each cycle: seen_mask |= com_seen.
  - skew_cnt starts at 0 in the cycle the first COM arrives and increments every cycle after that.
  - Pass: seen_mask including the current cycle's pulses is all ones while skew_cnt<MAX_SKEW. Then go to ALIGNED next cycle. Same-cycle COM on all lanes passes immediately.
  - Fail: skew_cnt reaches MAX_SKEW with the mask incomplete. Then retry_cnt+1 (saturating) and go to FLUSH.
  - A repeat com_seen on a lane already marked is ignored.
  - A ts_obtained drop also goes to FLUSH, without incrementing retry_cnt.
- ALIGNED: lanes_aligned=1 and deskew_en=1.
  - retry_cnt is cleared on entry.
  - A ts_obtained drop goes to FLUSH; lanes_aligned falls the next cycle.
- FLUSH: fifo_flush=1 and deskew_en=0 for exactly FLUSH_CYCLES cycles.
  - seen_mask and skew_cnt clear; window_cnt reloads to 1.
  - Afterwards: if retry_cnt==RETRY_MAX, go to FAIL; otherwise go to WAIT_LOCK.
- FAIL: align_fail=1, other outputs 0. Stays in FAIL until enable=0.
- enable=0 in any state goes to IDLE next cycle and clears all counters and the mask.
  - If leaving CATCH or ALIGNED this way, fifo_flush is asserted for the first IDLE cycle only.
- Width rules: window_cnt is 3 bits; MAX_SKEW must be ≤7. skew_cnt is clog2(MAX_SKEW+1) bits. retry_cnt saturates at 3.

Decomposition:
- Shared package rx_phy_pkg holds:
  - state enum: IDLE, WAIT_LOCK, WINDOW, CATCH, ALIGNED, FLUSH, FAIL;
  - constants COM=8'hBC and SKP=8'h1C;
  - the default MAX_SKEW.
- One natural sub-module: rx_skew_checker, containing seen_mask, skew_cnt and the pass/fail decision. It takes com_seen and an arm/clear input, and outputs pass/fail pulses.
- The FSM, window counter, flush timer and retry counter stay in the top module.

Test Plan:
- Nominal: enable=1; ts_obtained goes 01 then 11 two cycles later. Required: window_cnt runs 1,2,3,4; deskew_en rises 1 cycle after window_cnt==4. com_seen=11 in one cycle gives lanes_aligned=1 the next cycle, retry_cnt=0.
- Max skew edges: lane0 COM at t, lane1 at t+3 gives ALIGNED. Lane1 COM at t+4 instead gives FLUSH: fifo_flush high 2 cycles, retry_cnt=1, then return to WAIT_LOCK.
- Retry exhaustion: only lane0 ever sends COM, 3 times. Required: retry_cnt 1,2,3, then align_fail=1 held with enable=1. Dropping enable gives IDLE next cycle and all outputs 0.
- Lock loss while aligned: in ALIGNED, drop ts_obtained[1]. Required: FLUSH for 2 cycles with retry_cnt unchanged at 0, lanes_aligned=0, then WAIT_LOCK with window_cnt=1.
- Window abort: in WINDOW at window_cnt=3, drop ts_obtained[0]. Required: WAIT_LOCK, window_cnt=1, deskew_en never asserted.
- Reset mid-CATCH: reset=1 for 1 cycle with the mask half set. Required: every output 0, window_cnt=1, and the next acquisition re-runs from IDLE.
